// File: rtl/buffer_read_counter_unit_pkg.sv
// Shared types and default sizing for the buffer read counter unit.
// The request-entry struct matches the default field widths.
package buffer_read_counter_unit_pkg;

   localparam int NUM_PU_DEF         = 1;
   localparam int D_TYPE_W_DEF       = 2;
   localparam int RD_SIZE_W_DEF      = 20;
   localparam int PU_ID_W_DEF        = $clog2(NUM_PU_DEF) + 1;
   localparam int BUFFER_D_TYPE_DEF  = 1;
   localparam int RQ_FIFO_ADDR_W_DEF = 3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } brc_state_t;

   typedef struct packed {
      logic [RD_SIZE_W_DEF-1:0] size;
      logic [PU_ID_W_DEF-1:0]   pu_id;
   } rd_req_entry_t;

endpackage

// File: rtl/buffer_read_counter_unit_request_fifo.sv
// Synchronous FIFO holding queued read requests; pushes into a full FIFO are dropped.
// Extra pointer MSB distinguishes full from empty.
module buffer_read_counter_unit_request_fifo #(
   parameter int DATA_W = 21,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

endmodule

// File: rtl/buffer_read_counter_unit.sv
// Queues buffer-type read requests and counts consumer pops of each one in order,
// flagging the final word of every request.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no request being served; loads the FIFO head when present
//   ST_ACTIVE | serving cur_size words for pu_id; counts buffer_read_pop
module buffer_read_counter_unit
   import buffer_read_counter_unit_pkg::*;
#(
   parameter int                  NUM_PU         = NUM_PU_DEF,
   parameter int                  D_TYPE_W       = D_TYPE_W_DEF,
   parameter int                  RD_SIZE_W      = RD_SIZE_W_DEF,
   parameter int                  PU_ID_W        = $clog2(NUM_PU) + 1,
   parameter logic [D_TYPE_W-1:0] BUFFER_D_TYPE  = D_TYPE_W'(BUFFER_D_TYPE_DEF),
   parameter int                  RQ_FIFO_ADDR_W = RQ_FIFO_ADDR_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rd_req,
   input  logic [RD_SIZE_W-1:0] rd_req_size,
   input  logic [PU_ID_W-1:0]   rd_req_pu_id,
   input  logic [D_TYPE_W-1:0]  rd_req_d_type,
   input  logic                 buffer_read_empty,
   input  logic                 buffer_read_pop,
   output logic                 buffer_read_req,
   output logic                 buffer_read_last,
   output logic [PU_ID_W-1:0]   pu_id
);

   localparam int                   ENTRY_W  = RD_SIZE_W + PU_ID_W;
   localparam logic [RD_SIZE_W-1:0] SIZE_ONE = RD_SIZE_W'(1);

   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [ENTRY_W-1:0]   fifo_wr_data;
   logic [ENTRY_W-1:0]   fifo_rd_data;
   logic [RD_SIZE_W-1:0] head_size;
   logic [PU_ID_W-1:0]   head_pu_id;

   brc_state_t           state;
   brc_state_t           state_nxt;
   logic [RD_SIZE_W-1:0] cur_size;
   logic [RD_SIZE_W-1:0] cur_size_nxt;
   logic [RD_SIZE_W-1:0] counter;
   logic [RD_SIZE_W-1:0] counter_nxt;
   logic [PU_ID_W-1:0]   pu_id_nxt;
   logic                 at_last_word;

   // Only buffer-type reads are tracked; everything else passes by untouched.
   assign fifo_push    = rd_req && (rd_req_d_type == BUFFER_D_TYPE);
   assign fifo_wr_data = {rd_req_size, rd_req_pu_id};
   assign {head_size, head_pu_id} = fifo_rd_data;
   assign at_last_word = (counter == (cur_size - SIZE_ONE));

   buffer_read_counter_unit_request_fifo #(
      .DATA_W (ENTRY_W),
      .ADDR_W (RQ_FIFO_ADDR_W)
   ) u_request_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .wr_data (fifo_wr_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         cur_size <= '0;
         counter  <= '0;
         pu_id    <= '0;
      end else begin
         state    <= state_nxt;
         cur_size <= cur_size_nxt;
         counter  <= counter_nxt;
         pu_id    <= pu_id_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      cur_size_nxt     = cur_size;
      counter_nxt      = counter;
      pu_id_nxt        = pu_id;
      fifo_pop         = 1'b0;
      buffer_read_req  = 1'b0;
      buffer_read_last = 1'b0;
      case (state)
         ST_IDLE: begin
            // A zero-length head is popped and dropped without touching pu_id.
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (head_size != '0) begin
                  cur_size_nxt = head_size;
                  pu_id_nxt    = head_pu_id;
                  counter_nxt  = '0;
                  state_nxt    = ST_ACTIVE;
               end
            end
         end
         ST_ACTIVE: begin
            buffer_read_req = !buffer_read_empty;
            if (buffer_read_pop) begin
               counter_nxt = counter + SIZE_ONE;
               if (at_last_word) begin
                  buffer_read_last = 1'b1;
                  state_nxt        = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_buffer_read_counter_unit.sv
// Directed self-checking bench for buffer_read_counter_unit.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_buffer_read_counter_unit;
   import buffer_read_counter_unit_pkg::*;

   localparam int RD_SIZE_W = RD_SIZE_W_DEF;
   localparam int PU_ID_W   = PU_ID_W_DEF;
   localparam int D_TYPE_W  = D_TYPE_W_DEF;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 rd_req = 1'b0;
   logic [RD_SIZE_W-1:0] rd_req_size = '0;
   logic [PU_ID_W-1:0]   rd_req_pu_id = '0;
   logic [D_TYPE_W-1:0]  rd_req_d_type = '0;
   logic                 buffer_read_empty = 1'b1;
   logic                 buffer_read_pop = 1'b0;
   logic                 buffer_read_req;
   logic                 buffer_read_last;
   logic [PU_ID_W-1:0]   pu_id;

   int checks = 0;
   int failures = 0;
   int outstanding = 0;
   int pops_total = 0;

   rd_req_entry_t req_tab [10];

   buffer_read_counter_unit dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .rd_req            (rd_req),
      .rd_req_size       (rd_req_size),
      .rd_req_pu_id      (rd_req_pu_id),
      .rd_req_d_type     (rd_req_d_type),
      .buffer_read_empty (buffer_read_empty),
      .buffer_read_pop   (buffer_read_pop),
      .buffer_read_req   (buffer_read_req),
      .buffer_read_last  (buffer_read_last),
      .pu_id             (pu_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset_n && buffer_read_pop && buffer_read_empty) begin
         failures++;
         $error("FAIL illegal_pop observed=pop_with_empty expected=no_pop");
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic push(input int size, input int pu, input int dt);
      rd_req        = 1'b1;
      rd_req_size   = size[RD_SIZE_W-1:0];
      rd_req_pu_id  = pu[PU_ID_W-1:0];
      rd_req_d_type = dt[D_TYPE_W-1:0];
      cyc();
      rd_req = 1'b0;
      if (dt == BUFFER_D_TYPE_DEF) outstanding++;
      if (outstanding > 8) begin
         failures++;
         $error("FAIL overflow observed=%0d expected=<=8", outstanding);
      end
   endtask

   // Wait for the request to become active, then pop it with optional empty gaps.
   task automatic serve(input int size, input int pu, input int gap_at, input int gap_len,
                        input bit rnd, input string tag);
      int n;
      int lasts;
      int bad;
      buffer_read_pop   = 1'b0;
      buffer_read_empty = 1'b0;
      #1;
      n = 0;
      while (!buffer_read_req && n < 20) begin
         cyc();
         #1;
         n++;
      end
      chk({tag, "_start"}, 32'(buffer_read_req), 32'd1);
      if (buffer_read_req) begin
         lasts = 0;
         bad   = 0;
         for (int i = 0; i < size; i++) begin
            int g;
            g = rnd ? int'($urandom_range(0, 2)) : ((i == gap_at) ? gap_len : 0);
            for (int k = 0; k < g; k++) begin
               buffer_read_empty = 1'b1;
               buffer_read_pop   = 1'b0;
               #1;
               if (buffer_read_req || buffer_read_last) bad++;
               cyc();
            end
            buffer_read_empty = 1'b0;
            buffer_read_pop   = 1'b1;
            #1;
            if (buffer_read_req !== 1'b1) bad++;
            if (pu_id !== pu[PU_ID_W-1:0]) bad++;
            if (buffer_read_last === 1'b1) begin
               lasts++;
               if (i != size - 1) bad++;
            end
            pops_total++;
            cyc();
         end
         buffer_read_pop = 1'b0;
         #1;
         chk({tag, "_last_count"}, 32'(lasts), 32'd1);
         chk({tag, "_pop_errors"}, 32'(bad), 32'd0);
         chk({tag, "_idle_after_last"}, 32'(buffer_read_req), 32'd0);
         outstanding--;
      end
   endtask

   initial begin
      int cnt;
      int sum;

      // Reset state
      #1;
      chk("rst_req", 32'(buffer_read_req), 32'd0);
      chk("rst_last", 32'(buffer_read_last), 32'd0);
      chk("rst_pu_id", 32'(pu_id), 32'd0);
      cyc(); cyc(); cyc();
      reset_n = 1'b1;
      cyc();

      // Single request of 4 words to PU 0
      push(4, 0, 1);
      #1;
      chk("t1_load_latency", 32'(buffer_read_req), 32'd0);
      serve(4, 0, -1, 0, 1'b0, "t1");
      chk("t1_pu_id", 32'(pu_id), 32'd0);

      // Non-buffer d_type is ignored, and pops in IDLE do nothing
      cyc();
      push(5, 1, 0);
      buffer_read_empty = 1'b0;
      buffer_read_pop   = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (buffer_read_req || buffer_read_last) cnt++;
         cyc();
      end
      buffer_read_pop = 1'b0;
      chk("t3_ignored_dtype", 32'(cnt), 32'd0);
      chk("t3_pu_id_hold", 32'(pu_id), 32'd0);

      // Zero-size request is discarded, size-2 request follows
      push(0, 1, 1);
      outstanding--;
      cyc(); cyc();
      #1;
      chk("t4_zero_no_req", 32'(buffer_read_req), 32'd0);
      chk("t4_zero_pu_hold", 32'(pu_id), 32'd0);
      cyc();
      push(2, 1, 1);
      serve(2, 1, -1, 0, 1'b0, "t4");
      chk("t4_pu_id", 32'(pu_id), 32'd1);

      // Empty held for 10 cycles mid-request freezes the count
      cyc();
      push(3, 0, 1);
      serve(3, 0, 1, 10, 1'b0, "t5");

      // Ten random requests served in order with random gaps
      cyc();
      sum = 0;
      pops_total = 0;
      for (int i = 0; i < 10; i++) begin
         req_tab[i].size  = RD_SIZE_W'($urandom_range(1, 16));
         req_tab[i].pu_id = PU_ID_W'($urandom_range(0, 1));
         sum += int'(req_tab[i].size);
      end
      for (int i = 0; i < 8; i++) push(int'(req_tab[i].size), int'(req_tab[i].pu_id), 1);
      for (int i = 0; i < 2; i++) serve(int'(req_tab[i].size), int'(req_tab[i].pu_id), -1, 0, 1'b1, "t2");
      cyc();
      for (int i = 8; i < 10; i++) push(int'(req_tab[i].size), int'(req_tab[i].pu_id), 1);
      for (int i = 2; i < 10; i++) serve(int'(req_tab[i].size), int'(req_tab[i].pu_id), -1, 0, 1'b1, "t2");
      chk("t2_total_pops", 32'(pops_total), 32'(sum));

      // Reset after 2 of 8 pops with 3 more requests queued
      cyc();
      push(8, 1, 1);
      push(2, 0, 1);
      push(3, 0, 1);
      push(4, 0, 1);
      buffer_read_empty = 1'b0;
      #1;
      cnt = 0;
      while (!buffer_read_req && cnt < 20) begin
         cyc();
         #1;
         cnt++;
      end
      chk("t6_active", 32'(buffer_read_req), 32'd1);
      cnt = 0;
      for (int i = 0; i < 2; i++) begin
         buffer_read_pop = 1'b1;
         #1;
         if (buffer_read_last !== 1'b0) cnt++;
         cyc();
      end
      chk("t6_no_early_last", 32'(cnt), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_req", 32'(buffer_read_req), 32'd0);
      chk("t6_rst_last", 32'(buffer_read_last), 32'd0);
      chk("t6_rst_pu_id", 32'(pu_id), 32'd0);
      buffer_read_pop = 1'b0;
      cyc();
      reset_n = 1'b1;
      outstanding = 0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (buffer_read_req) cnt++;
         cyc();
      end
      chk("t6_flushed", 32'(cnt), 32'd0);
      push(1, 1, 1);
      serve(1, 1, -1, 0, 1'b0, "t6_new");
      chk("t6_new_pu_id", 32'(pu_id), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
